// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-to-APB bridge: AHB transfer/response codes and FSM states.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HR_OKAY  = 2'b00,
    HR_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Slave-index field width; a single slave still gets one decode bit.
  function automatic int sel_width(input int nslv);
    return (nslv > 1) ? $clog2(nslv) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// Decodes the slave-index field of a registered AHB address into a one-hot APB select.
module apb_slave_decoder
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NSLV    = 3,
  parameter int SEL_LSB = 12
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NSLV-1:0]   sel,
  output logic              valid
);

  localparam int SW = sel_width(NSLV);

  logic [SW-1:0] idx;
  logic          unused_addr;

  assign idx         = addr[SEL_LSB +: SW];
  assign unused_addr = ^addr;

  // Indices at or above NSLV match no bit, which is what flags the hole.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NSLV; i++) sel[i] = (idx == SW'(i));
  end

  assign valid = |sel;

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-lite slave to APB master bridge: one outstanding transfer, wait-state timeout,
// and a two-cycle AHB ERROR response for decode holes, slave errors and timeouts.
module ahb2apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 3,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic                   HREADYIN,
  input  logic [ADDR_W-1:0]      HADDR,
  input  logic [DATA_W-1:0]      HWDATA,
  output logic [DATA_W-1:0]      HRDATA,
  output logic                   HREADYOUT,
  output logic [1:0]             HRESP,
  output logic [NSLV-1:0]        PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic [NSLV*DATA_W-1:0] PRDATA,
  input  logic [NSLV-1:0]        PREADY,
  input  logic [NSLV-1:0]        PSLVERR
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] haddr_r;
  logic              hwrite_r;
  logic [NSLV-1:0]   sel_r, dec_sel;
  logic              dec_valid;
  logic [CW-1:0]     wait_cnt;
  logic              req, load, sel_ready, sel_err, timeout;
  logic [DATA_W-1:0] sel_rdata;

  apb_slave_decoder #(
    .ADDR_W (ADDR_W),
    .NSLV   (NSLV),
    .SEL_LSB(SEL_LSB)
  ) u_dec (
    .addr (haddr_r),
    .sel  (dec_sel),
    .valid(dec_valid)
  );

  assign req       = ((HTRANS == HT_NONSEQ) || (HTRANS == HT_SEQ)) && HREADYIN;
  assign sel_ready = |(PREADY & sel_r);
  assign sel_err   = |(PSLVERR & sel_r);
  // Abort on the ACCESS cycle whose miss would bring the count up to TIMEOUT.
  assign timeout   = (TIMEOUT > 0) && !sel_ready && (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++)
      if (sel_r[i]) sel_rdata = sel_rdata | PRDATA[i*DATA_W +: DATA_W];
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = HR_OKAY;
    HRDATA    = '0;
    PSEL      = '0;
    PENABLE   = 1'b0;
    case (state)
      ST_IDLE: if (req) begin
        state_nxt = ST_LATCH;
        load      = 1'b1;
      end
      ST_LATCH: begin
        HREADYOUT = 1'b0;
        state_nxt = dec_valid ? ST_SETUP : ST_ERR1;
      end
      ST_SETUP: begin
        HREADYOUT = 1'b0;
        PSEL      = sel_r;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        HREADYOUT = 1'b0;
        PSEL      = sel_r;
        PENABLE   = 1'b1;
        if (sel_ready && sel_err) begin
          state_nxt = ST_ERR1;
        end else if (sel_ready) begin
          HREADYOUT = 1'b1;
          if (!PWRITE) HRDATA = sel_rdata;
          state_nxt = req ? ST_LATCH : ST_IDLE;
          load      = req;
        end else if (timeout) begin
          state_nxt = ST_ERR1;
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HR_ERROR;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP     = HR_ERROR;
        state_nxt = req ? ST_LATCH : ST_IDLE;
        load      = req;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      haddr_r  <= '0;
      hwrite_r <= 1'b0;
      sel_r    <= '0;
      wait_cnt <= '0;
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        haddr_r  <= HADDR;
        hwrite_r <= HWRITE;
      end
      // APB-side address/control only move for a decoded transfer.
      if (state == ST_LATCH && dec_valid) begin
        PADDR  <= haddr_r;
        PWRITE <= hwrite_r;
        PWDATA <= HWDATA;
        sel_r  <= dec_sel;
      end
      if (state == ST_SETUP) wait_cnt <= '0;
      else if (state == ST_ACCESS && !sel_ready) wait_cnt <= wait_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Scoreboard bench for ahb2apb_bridge: random AHB transfers and APB slave wait/error plans.
module tb_ahb2apb_bridge;
  import ahb_apb_pkg::*;

  localparam int AW = 32, DW = 32, NS = 3, SL = 12, TO = 16;

  logic            hclk = 1'b0;
  logic            hreset, hwrite, hreadyin, hreadyout, hready_mask;
  logic [1:0]      htrans, hresp;
  logic [AW-1:0]   haddr, paddr;
  logic [DW-1:0]   hwdata, hrdata, pwdata;
  logic [NS-1:0]   psel, pready, pslverr;
  logic            penable, pwrite;
  logic [NS*DW-1:0] prdata;

  always #5 hclk = ~hclk;
  assign hreadyin = hreadyout & hready_mask;

  ahb2apb_bridge #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS), .SEL_LSB(SL), .TIMEOUT(TO)) dut (
    .HCLK(hclk), .HRESET(hreset), .HTRANS(htrans), .HWRITE(hwrite), .HREADYIN(hreadyin),
    .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  typedef struct { logic err; logic [DW-1:0] rdata; int lat; } exp_t;
  typedef struct { logic [NS-1:0] sel; logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata; } apb_t;
  typedef struct { int w; logic err; logic [DW-1:0] rdata; } plan_t;

  exp_t  sb_q[$];
  apb_t  apb_q[$];
  plan_t plan_q[$];
  int    n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: latency counted in cycles from the address phase (cycle 0) to HREADYOUT=1.
  function automatic exp_t model(input logic [AW-1:0] a, input logic wr, input plan_t p);
    exp_t e;
    int idx = int'(a[SL +: 2]);
    e.err = 1'b0; e.rdata = '0; e.lat = 0;
    if (idx >= NS)                    begin e.err = 1'b1; e.lat = 3; end
    else if (TO > 0 && p.w >= TO)     begin e.err = 1'b1; e.lat = 4 + TO; end
    else if (p.err)                   begin e.err = 1'b1; e.lat = 5 + p.w; end
    else begin e.lat = 3 + p.w; if (!wr) e.rdata = p.rdata; end
    return e;
  endfunction

  task automatic issue(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                       input int w, input logic er, input logic [DW-1:0] rd);
    plan_t p; apb_t x; int idx; int n;
    p.w = w; p.err = er; p.rdata = rd;
    sb_q.push_back(model(a, wr, p));
    idx = int'(a[SL +: 2]);
    if (idx < NS) begin
      x.sel = NS'(1) << idx; x.addr = a; x.wr = wr; x.wdata = wd;
      apb_q.push_back(x);
      plan_q.push_back(p);
    end
    htrans = ($urandom_range(0, 1) != 0) ? HT_SEQ : HT_NONSEQ;
    haddr  = a;
    hwrite = wr;
    n = 0;
    do begin @(negedge hclk); n++; end while (!hreadyin && n < 200);
    if (!hreadyin) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_wait: got no HREADYOUT expected one within 200 cycles at %0t", $time);
    end
    @(posedge hclk); #1;
    htrans = HT_IDLE;
    hwdata = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      htrans = ($urandom_range(0, 1) != 0) ? HT_BUSY : HT_IDLE;
      @(posedge hclk); #1;
    end
    htrans = HT_IDLE;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 400) begin @(negedge hclk); n++; end
    check("drain_pending", 32'(sb_q.size()), 32'd0);
    @(posedge hclk); #1;
  endtask

  // Monitor: AHB completions against the scoreboard, APB SETUP/ACCESS against apb_q.
  initial begin : mon
    bit pend = 0;
    int cyc = 0;
    exp_t e;
    apb_t a;
    logic [NS-1:0] l_sel; logic [AW-1:0] l_addr; logic l_wr; logic [DW-1:0] l_wd;
    l_sel = '0; l_addr = '0; l_wr = 1'b0; l_wd = '0;
    forever begin
      @(negedge hclk);
      if (hreset) begin
        pend = 0;
      end else begin
        if (pend) cyc++;
        if (pend && hreadyout) begin
          if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_completion: got HREADYOUT=1 expected no transfer at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            check("hresp", 32'(hresp), e.err ? 32'd1 : 32'd0);
            check("hrdata", hrdata, e.rdata);
            check("latency", 32'(cyc), 32'(e.lat));
          end
          pend = 0;
        end else if (pend) begin
          check("hrdata_wait", hrdata, 32'd0);
          check("hresp_wait", 32'(hresp),
                (sb_q.size() > 0 && sb_q[0].err && cyc == sb_q[0].lat - 1) ? 32'd1 : 32'd0);
        end else begin
          check("idle_ready", 32'(hreadyout), 32'd1);
          check("idle_hresp", 32'(hresp), 32'd0);
          check("idle_hrdata", hrdata, 32'd0);
        end
        if (htrans[1] && hreadyin) begin pend = 1; cyc = 0; end

        if (psel != '0 && !penable) begin
          if (apb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_setup: got PSEL=%0h expected none at %0t", psel, $time);
          end else begin
            a = apb_q.pop_front();
            check("psel", 32'(psel), 32'(a.sel));
            check("paddr", paddr, a.addr);
            check("pwrite", 32'(pwrite), 32'(a.wr));
            if (a.wr) check("pwdata", pwdata, a.wdata);
          end
          l_sel = psel; l_addr = paddr; l_wr = pwrite; l_wd = pwdata;
        end else if (penable) begin
          check("access_psel", 32'(psel), 32'(l_sel));
          check("access_paddr", paddr, l_addr);
          check("access_pwrite", 32'(pwrite), 32'(l_wr));
          check("access_pwdata", pwdata, l_wd);
        end
      end
    end
  end

  // APB slaves: the selected one follows its plan; the others drive noise.
  initial begin : slv
    plan_t p;
    int k, s;
    pready = '0; pslverr = '0; prdata = '0;
    forever begin
      @(negedge hclk);
      if (!hreset && psel != '0 && !penable) begin
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else begin p.w = 0; p.err = 1'b0; p.rdata = '0; end
        s = 0;
        for (int i = 0; i < NS; i++) if (psel[i]) s = i;
        k = 0;
        forever begin
          @(posedge hclk); #1;
          if (psel == '0 || !penable || k > 1000) break;
          pready  = NS'($urandom);
          pslverr = NS'($urandom);
          for (int i = 0; i < NS; i++) prdata[i*DW +: DW] = $urandom;
          pready[s]  = (k >= p.w);
          pslverr[s] = (k >= p.w) && p.err;
          prdata[s*DW +: DW] = p.rdata;
          k++;
        end
        pready  = NS'($urandom);
        pslverr = NS'($urandom);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected one by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [AW-1:0] a;
    int idx, w;
    htrans = HT_IDLE; hwrite = 1'b0; haddr = '0; hwdata = '0; hready_mask = 1'b1; hreset = 1'b1;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;

    issue(32'h0000_1004, 1'b1, 32'hA5A5_5A5A, 0, 1'b0, 32'h0);
    idle(2);
    issue(32'h0000_2000, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678);
    idle(1);
    issue(32'h0000_3000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    idle(1);
    issue(32'h0000_0010, 1'b0, 32'h0, 16, 1'b0, 32'h7777_7777);
    issue(32'h0000_0020, 1'b0, 32'h0, 15, 1'b0, 32'hCAFE_F00D);
    issue(32'h0000_1008, 1'b1, 32'hDEAD_BEEF, 2, 1'b1, 32'h0);
    issue(32'h0000_1010, 1'b1, 32'h3C3C_C3C3, 0, 1'b0, 32'h0);
    issue(32'h0000_2010, 1'b0, 32'h0, 1, 1'b0, 32'h0BAD_CAFE);
    drain();

    hready_mask = 1'b0;
    htrans = HT_NONSEQ; haddr = 32'h0000_1000; hwrite = 1'b1;
    repeat (3) begin
      @(negedge hclk);
      check("hreadyin_low_ready", 32'(hreadyout), 32'd1);
      check("hreadyin_low_psel", 32'(psel), 32'd0);
    end
    @(posedge hclk); #1;
    htrans = HT_IDLE; hready_mask = 1'b1;

    for (int t = 0; t < 80; t++) begin
      idx = $urandom_range(0, 3);
      a = $urandom;
      a[13:12] = idx[1:0];
      a[1:0] = 2'b00;
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
      issue(a, 1'($urandom_range(0, 1)), $urandom, w, ($urandom_range(0, 5) == 0), $urandom);
      idle($urandom_range(0, 2));
    end
    drain();

    issue(32'h0000_1ABC, 1'b1, 32'h5555_AAAA, 10, 1'b0, 32'h0);
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_pre_penable", 32'(penable), 32'd1);
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    sb_q.delete(); apb_q.delete(); plan_q.delete();
    @(negedge hclk);
    check("midrst_psel", 32'(psel), 32'd0);
    check("midrst_penable", 32'(penable), 32'd0);
    check("midrst_pwrite", 32'(pwrite), 32'd0);
    check("midrst_paddr", paddr, 32'd0);
    check("midrst_pwdata", pwdata, 32'd0);
    check("midrst_hreadyout", 32'(hreadyout), 32'd1);
    repeat (3) @(posedge hclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
